mem_lsu: RTL

//  Load/store unit between the CPU memory stage and the word-wide data ram
//  (sync write, async read). Accepts byte/half/word loads and stores on a

---
 rtl/mem_lsu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- load/store unit between the CPU memory stage and a word-wide
// data ram (synchronous write, combinational read).
//
// A request is accepted in IDLE and its fields are latched. Loads read one
// word, extract the addressed byte/half lane and sign- or zero-extend it.
// Word stores write directly. Byte/half stores read the word in ACCESS, then
// write back the merged word in MERGE. The response is held on rsp_* until
// rsp_ready. Little-endian: byte lane = addr[1:0], lane 0 = bits 7:0.
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN):
//   defined   : misaligned half/word or size=11 go IDLE->RESP with rsp_err=1,
//               rsp_rdata=0 and no ram access.
//   undefined : low address bits are masked, size=11 acts as word,
//               rsp_err is tied 0.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_size, req_sign      store flag, 00 b/01 h/10 w/11 rsvd, sign-ext
//   req_addr [N+1:0], req_wdata     byte address, right-justified store data
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              load result (0 for stores), error flag
//   ram_we, ram_adr [N-1:0]         ram write enable, word address
//   ram_din, ram_dout               ram write data, ram read data
// -----------------------------------------------------------------------------
module mem_lsu #(
  parameter int N = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_sign,
  input  logic [N+1:0]  req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_we,
  output logic [N-1:0]  ram_adr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t        state;
  logic [N+1:0]  addr_q;
  logic [1:0]    size_q;
  logic          sign_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   merge_q;
  logic [31:0]   rdata_q;
  logic          valid_q;

  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_val;
  logic [31:0]   merged;

  // Lane extraction for loads and lane insertion for sub-word stores.
  // size_q[1] set means word (size=11 falls into the word path).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lane_b   = ram_dout[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    load_val = ram_dout;
    merged   = merge_q;
    case (size_q)
      2'b00:   load_val = {{24{sign_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{sign_q & lane_h[15]}}, lane_h};
      default: load_val = ram_dout;
    endcase
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // NOTE: ram_we decodes straight from state, so an async reset removes it
  // immediately and a store caught before its write edge is simply dropped.
  assign ram_we    = (state == MERGE) || (state == ACCESS && we_q && size_q[1]);
  assign ram_din   = (state == MERGE) ? merged : wdata_q;
  assign ram_adr   = addr_q[N+1:2];
  assign req_ready = (state == IDLE);
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  logic misalign;
  assign misalign = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign rsp_err  = err_q;
`else
  assign rsp_err  = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            sign_q  <= req_sign;
            we_q    <= req_we;
            wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign) begin
              state   <= RESP;
              valid_q <= 1'b1;
              rdata_q <= '0;
              err_q   <= 1'b1;
            end else
`endif
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_val;
            valid_q <= 1'b1;
            state   <= RESP;
          end else if (size_q[1]) begin
            rdata_q <= '0;
            valid_q <= 1'b1;
            state   <= RESP;
          end else begin
            merge_q <= ram_dout;
            state   <= MERGE;
          end
        end
        MERGE: begin
          rdata_q <= '0;
          valid_q <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
